alu_md: RTL and testbench

ALU_MD -- requirements
Module: alu_md

---
 rtl/alu_md.sv | 159 +++++++++++++++
 tb/tb_alu_md.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// Integer ALU with single-cycle logic/arith ops plus iterative multiply and divide.
// One request in flight; the result is held in DONE until the consumer takes it.
module alu_md #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   in_op,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_res
);
    localparam int SW = $clog2(N);

    // valid/ready: a request transfers on a rising edge with in_valid && in_ready;
    // a result transfers on a rising edge with out_valid && out_ready.
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [4:0]     op_q, op_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   mag_q, mag_d;
    logic           neg_q, neg_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   res_q, res_d;

    logic           accept;
    logic           is_multi;
    logic [SW-1:0]  shamt;
    logic [N-1:0]   alu_res;
    logic           sgn_a, sgn_b;
    logic [N-1:0]   mag_a, mag_b;
    logic [N:0]     mul_sum;
    logic [N:0]     div_t;
    logic           div_ge;
    logic [N-1:0]   div_r;
    logic [2*N-1:0] acc_step;
    logic [2*N-1:0] mul_full;
    logic [N-1:0]   div_sel;
    logic [N-1:0]   multi_res;

    assign in_ready  = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign is_multi  = (in_op[4:3] == 2'b10);
    assign shamt     = in_b[SW-1:0];
    assign out_valid = (state_q == DONE);
    assign out_res   = res_q;

    always_comb begin
        alu_res = '0;
        case (in_op)
            5'b00000: alu_res = in_a + in_b;
            5'b00001: alu_res = in_a << shamt;
            5'b00010: alu_res = {{(N-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            5'b00011: alu_res = {{(N-1){1'b0}}, (in_a < in_b)};
            5'b00100: alu_res = in_a ^ in_b;
            5'b00101: alu_res = in_a >> shamt;
            5'b00110: alu_res = in_a | in_b;
            5'b00111: alu_res = in_a & in_b;
            5'b01100: alu_res = in_a - in_b;
            5'b01101: alu_res = $signed(in_a) >>> shamt;
            5'b01111: alu_res = in_b;
            default:  alu_res = '0;
        endcase
    end

    // Both iterative engines work on magnitudes; the sign is reapplied at the end.
    always_comb begin
        if (in_op[2]) begin
            sgn_a = ~in_op[0] & in_a[N-1];
            sgn_b = ~in_op[0] & in_b[N-1];
        end else begin
            sgn_a = (in_op[1] ^ in_op[0]) & in_a[N-1];
            sgn_b = (~in_op[1] & in_op[0]) & in_b[N-1];
        end
        mag_a = sgn_a ? (N'(0) - in_a) : in_a;
        mag_b = sgn_b ? (N'(0) - in_b) : in_b;
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mag_q} : '0);
        div_t   = {acc_q[2*N-1:N], acc_q[N-1]};
        div_ge  = (div_t >= {1'b0, mag_q});
        div_r   = div_ge ? N'(div_t - {1'b0, mag_q}) : div_t[N-1:0];
        if (op_q[2]) acc_step = {div_r, acc_q[N-2:0], div_ge};
        else         acc_step = {mul_sum, acc_q[N-1:1]};

        mul_full = neg_q ? ((2*N)'(0) - acc_step) : acc_step;
        div_sel  = op_q[1] ? acc_step[2*N-1:N] : acc_step[N-1:0];
        if (op_q[2])                multi_res = neg_q ? (N'(0) - div_sel) : div_sel;
        else if (op_q[1:0] == 2'b00) multi_res = mul_full[N-1:0];
        else                        multi_res = mul_full[2*N-1:N];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        if (state_q == BUSY) begin
            acc_d = acc_step;
            cnt_d = cnt_q + SW'(1);
            if (cnt_q == SW'(N-1)) begin
                res_d   = multi_res;
                state_d = DONE;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
        if (accept) begin
            op_d = in_op;
            if (is_multi) begin
                state_d = BUSY;
                cnt_d   = '0;
                if (in_op[2]) begin
                    mag_d = mag_b;
                    acc_d = {{N{1'b0}}, mag_a};
                    // Divide-by-zero leaves an all-ones quotient, so it must not be negated.
                    neg_d = in_op[1] ? sgn_a : ((sgn_a ^ sgn_b) & (in_b != '0));
                end else begin
                    mag_d = mag_a;
                    acc_d = {{N{1'b0}}, mag_b};
                    neg_d = sgn_a ^ sgn_b;
                end
            end else begin
                state_d = DONE;
                res_d   = alu_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md at N=32: hand-computed vectors, latency, hold and reset-abort cases.
module tb_alu_md;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   in_op;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_res;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_md #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE, waits for the result, consumes it.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] exp, input int exp_lat);
        int lat;
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_op    = 5'($urandom_range(0, 31));
        in_a     = $urandom;
        in_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_res"}, 64'(out_res), 64'(exp));
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        if (exp_lat != 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        tick();
        check({tag, "_idle"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        repeat (3) tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_res", 64'(out_res), 64'd0);
        check("rst_rdy", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_rdy", 64'(in_ready), 64'd1);

        run_op("add",    5'b00000, 32'd5,        32'd7,        32'd12,         1);
        run_op("sll",    5'b00001, 32'd1,        32'd35,       32'd8,          1);
        run_op("slt",    5'b00010, 32'hFFFFFFFF, 32'd1,        32'd1,          1);
        run_op("sltu",   5'b00011, 32'hFFFFFFFF, 32'd1,        32'd0,          1);
        run_op("op0e",   5'b01110, 32'd5,        32'd7,        32'd0,          1);
        run_op("xor",    5'b00100, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0,   1);
        run_op("srl",    5'b00101, 32'h80000000, 32'd4,        32'h08000000,   1);
        run_op("sra",    5'b01101, 32'h80000000, 32'd36,       32'hF8000000,   1);
        run_op("or",     5'b00110, 32'h00F0000F, 32'h0F000F00, 32'h0FF00F0F,   1);
        run_op("and",    5'b00111, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00,   1);
        run_op("sub",    5'b01100, 32'd3,        32'd5,        32'hFFFFFFFE,   1);
        run_op("passb",  5'b01111, 32'd9,        32'hCAFEBABE, 32'hCAFEBABE,   1);
        run_op("op18",   5'b11000, 32'd5,        32'd7,        32'd0,          0);
        run_op("mulh",   5'b10001, 32'h80000000, 32'h80000000, 32'h40000000,   33);
        run_op("mul",    5'b10000, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD,   33);
        run_op("mulhm1", 5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,   33);
        run_op("mulhu",  5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,   33);
        run_op("mulhsu", 5'b10010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF,   33);
        run_op("div0",   5'b10100, 32'd7,        32'd0,        32'hFFFFFFFF,   33);
        run_op("rem0",   5'b10110, 32'd7,        32'd0,        32'd7,          33);
        run_op("divn0",  5'b10100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF,   33);
        run_op("remn0",  5'b10110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9,   33);
        run_op("divovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,   33);
        run_op("removf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'd0,          33);
        run_op("divneg", 5'b10100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,   33);
        run_op("remneg", 5'b10110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,   33);
        run_op("divu",   5'b10101, 32'd100,      32'd7,        32'd14,         33);
        run_op("remu",   5'b10111, 32'd100,      32'd7,        32'd2,          33);

        // Hold in DONE with a competing request present; it must be ignored.
        in_valid  = 1'b1;
        in_op     = 5'b00000;
        in_a      = 32'd1;
        in_b      = 32'd2;
        out_ready = 1'b0;
        tick();
        in_op = 5'b00100;
        in_a  = 32'h1234;
        in_b  = 32'h4321;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_res", 64'(out_res), 64'd3);
            check("hold_rdy", 64'(in_ready), 64'd0);
            tick();
        end
        check("hold_res_end", 64'(out_res), 64'd3);
        in_op     = 5'b01100;
        in_a      = 32'd10;
        in_b      = 32'd4;
        out_ready = 1'b1;
        #1;
        check("b2b_rdy", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("b2b_valid", 64'(out_valid), 64'd1);
        check("b2b_res", 64'(out_res), 64'd6);
        tick();
        check("b2b_idle", 64'(out_valid), 64'd0);

        // Reset during the 10th BUSY cycle of a divu aborts it.
        in_valid = 1'b1;
        in_op    = 5'b10101;
        in_a     = 32'd1000;
        in_b     = 32'd3;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("busy_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rst_busy_rdy", 64'(in_ready), 64'd0);
        tick();
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_res", 64'(out_res), 64'd0);
        check("abort_rdy", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("abort_idle_rdy", 64'(in_ready), 64'd1);
        repeat (40) begin
            tick();
            if (out_valid) check("abort_no_result", 64'(out_valid), 64'd0);
        end
        run_op("divu_after", 5'b10101, 32'd100, 32'd7, 32'd14, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
